// File: rtl/comparator_pipe.sv
// Registered a-vs-b comparator with valid/ready handshake, plus running
// max/min of accepted i_a values and a saturating count of consecutive equal samples.
module comparator_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_signed,
  input  logic                  i_clr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_gt,
  output logic                  o_lt,
  output logic                  o_eq,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [DATA_WIDTH-1:0] o_min,
  output logic [CNT_WIDTH-1:0]  o_eq_run
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  valid_q, valid_d;
  logic                  gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [DATA_WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [CNT_WIDTH-1:0]  run_q, run_d;
  logic                  seen_q, seen_d;
  logic                  accept, a_gt_b, a_lt_b, a_eq_b;

  function automatic logic is_gt(input logic [DATA_WIDTH-1:0] x,
                                 input logic [DATA_WIDTH-1:0] y,
                                 input logic                  s);
    if (s) return $signed(x) > $signed(y);
    else   return x > y;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    else    return c + CNT_ONE;
  endfunction

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;
  assign a_gt_b  = is_gt(i_a, i_b, i_signed);
  assign a_lt_b  = is_gt(i_b, i_a, i_signed);
  assign a_eq_b  = (i_a == i_b);

  always_comb begin
    valid_d = valid_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    max_d   = max_q;
    min_d   = min_q;
    run_d   = run_q;
    seen_d  = seen_q;

    if (accept) begin
      valid_d = 1'b1;
      gt_d    = a_gt_b;
      lt_d    = a_lt_b;
      eq_d    = a_eq_b;
      // A clear coinciding with an accept restarts the trackers from this sample.
      if (i_clr || !seen_q) begin
        seen_d = 1'b1;
        max_d  = i_a;
        min_d  = i_a;
        run_d  = a_eq_b ? CNT_ONE : '0;
      end else begin
        if (is_gt(i_a, max_q, i_signed)) max_d = i_a;
        if (is_gt(min_q, i_a, i_signed)) min_d = i_a;
        run_d = a_eq_b ? sat_inc(run_q) : '0;
      end
    end else begin
      if (i_ready) valid_d = 1'b0;
      if (i_clr) begin
        seen_d = 1'b0;
        max_d  = '0;
        min_d  = '0;
        run_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
      run_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      max_q   <= max_d;
      min_q   <= min_d;
      run_q   <= run_d;
      seen_q  <= seen_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_gt     = gt_q;
  assign o_lt     = lt_q;
  assign o_eq     = eq_q;
  assign o_max    = max_q;
  assign o_min    = min_q;
  assign o_eq_run = run_q;

endmodule

// File: tb/tb_comparator_pipe.sv
// Randomised and directed bench for comparator_pipe against an integer-arithmetic reference model.
module tb_comparator_pipe;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int RUN_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_signed, i_clr, i_ready;
  logic [DW-1:0] i_a, i_b;
  logic          o_ready, o_valid, o_gt, o_lt, o_eq;
  logic [DW-1:0] o_max, o_min;
  logic [CW-1:0] o_eq_run;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid, m_gt, m_lt, m_eq, m_seen;
  logic [DW-1:0] m_max, m_min;
  int          m_run;
  int          m_results_out;

  comparator_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_clr(i_clr),
    .o_valid(o_valid), .i_ready(i_ready), .o_gt(o_gt), .o_lt(o_lt), .o_eq(o_eq),
    .o_max(o_max), .o_min(o_min), .o_eq_run(o_eq_run)
  );

  always #5 clk = ~clk;

  function automatic int val(input logic [DW-1:0] x, input bit s);
    int u;
    u = int'(x);
    if (s && u >= (1 << (DW-1))) return u - (1 << DW);
    return u;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_seen = 0;
    m_max = '0; m_min = '0; m_run = 0;
  endtask

  // Advance one clock: update the model from the current inputs, then land 1ns after the edge.
  task automatic tick();
    bit rdy, acc;
    int va, vb;
    rdy = !m_valid || i_ready;
    acc = i_valid && rdy;
    if (m_valid && i_ready) m_results_out++;
    if (acc) begin
      va = val(i_a, i_signed);
      vb = val(i_b, i_signed);
      m_valid = 1;
      m_gt = va > vb; m_lt = va < vb; m_eq = va == vb;
      if (i_clr || !m_seen) begin
        m_seen = 1; m_max = i_a; m_min = i_a; m_run = m_eq ? 1 : 0;
      end else begin
        if (va > val(m_max, i_signed)) m_max = i_a;
        if (va < val(m_min, i_signed)) m_min = i_a;
        m_run = m_eq ? ((m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1) : 0;
      end
    end else begin
      if (i_ready) m_valid = 0;
      if (i_clr) begin m_seen = 0; m_max = '0; m_min = '0; m_run = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 0; i_ready = 1; i_clr = 0; i_signed = 0; i_a = '0; i_b = '0;
    model_reset();
    m_results_out = 0;
    #2;
    checks++;
    if ({o_valid, o_gt, o_lt, o_eq} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {o_valid, o_gt, o_lt, o_eq});
    end
    checks++;
    if (o_max !== 8'h00 || o_min !== 8'h00 || o_eq_run !== 4'd0) begin
      errors++; $display("FAIL reset_trackers got max=%h min=%h run=%0d expected 0", o_max, o_min, o_eq_run);
    end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", o_ready); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b expected 1", o_ready); end
  endtask

  task automatic test_unsigned_basic();
    i_valid = 1; i_signed = 0; i_a = 8'h80; i_b = 8'h7F; i_ready = 1;
    tick();
    i_valid = 0;
    checks++;
    if ({o_valid, o_gt, o_lt, o_eq} !== 4'b1100) begin
      errors++; $display("FAIL unsigned_cmp got v/gt/lt/eq=%b expected 1100", {o_valid, o_gt, o_lt, o_eq});
    end
    checks++;
    if (o_max !== 8'h80 || o_min !== 8'h80) begin
      errors++; $display("FAIL unsigned_maxmin got %h/%h expected 80/80", o_max, o_min);
    end
  endtask

  task automatic test_signed();
    i_valid = 0; i_clr = 1; tick(); i_clr = 0;
    i_valid = 1; i_signed = 1; i_a = 8'h80; i_b = 8'h7F;
    tick();
    checks++;
    if ({o_valid, o_gt, o_lt, o_eq} !== 4'b1010) begin
      errors++; $display("FAIL signed_cmp got v/gt/lt/eq=%b expected 1010", {o_valid, o_gt, o_lt, o_eq});
    end
    i_a = 8'hFF; i_b = 8'h00;
    tick();
    i_valid = 0;
    checks++;
    if (o_max !== 8'hFF || o_min !== 8'h80) begin
      errors++; $display("FAIL signed_maxmin got %h/%h expected ff/80", o_max, o_min);
    end
    checks++;
    if (o_lt !== 1'b1) begin errors++; $display("FAIL signed_neg1_lt0 got %b expected 1", o_lt); end
  endtask

  task automatic test_backpressure();
    int out_before;
    i_valid = 0; i_ready = 1; i_clr = 1; tick(); i_clr = 0;
    out_before = m_results_out;
    i_valid = 1; i_signed = 0; i_a = 8'h30; i_b = 8'h10; i_ready = 0;
    tick();
    i_a = 8'h50; i_b = 8'h60;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d got %b expected 0", k, o_ready); end
      tick();
      checks++;
      if ({o_valid, o_gt, o_lt} !== 3'b110 || o_max !== 8'h30 || o_min !== 8'h30) begin
        errors++;
        $display("FAIL bp_hold_c%0d got v/gt/lt=%b max=%h min=%h expected 110 30 30",
                 k, {o_valid, o_gt, o_lt}, o_max, o_min);
      end
    end
    i_ready = 1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b expected 1", o_ready); end
    tick();
    checks++;
    if ({o_valid, o_gt, o_lt} !== 3'b101 || o_max !== 8'h50 || o_min !== 8'h30) begin
      errors++;
      $display("FAIL bp_second got v/gt/lt=%b max=%h min=%h expected 101 50 30",
               {o_valid, o_gt, o_lt}, o_max, o_min);
    end
    i_valid = 0;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b expected 0", o_valid); end
    checks++;
    if (m_results_out - out_before !== 2) begin
      errors++; $display("FAIL bp_result_count got %0d expected 2", m_results_out - out_before);
    end
  endtask

  task automatic test_eq_run();
    i_valid = 0; i_ready = 1; i_clr = 1; tick(); i_clr = 0;
    i_valid = 1;
    for (int k = 1; k <= 17; k++) begin
      i_a = DW'($urandom); i_b = i_a; i_signed = 1'($urandom);
      tick();
      checks++;
      if (int'(o_eq_run) !== ((k > RUN_MAX) ? RUN_MAX : k) || o_eq !== 1'b1) begin
        errors++; $display("FAIL eq_run_%0d got run=%0d eq=%b expected run=%0d eq=1",
                           k, o_eq_run, o_eq, (k > RUN_MAX) ? RUN_MAX : k);
      end
    end
    i_a = 8'h12; i_b = 8'h13;
    tick();
    i_valid = 0;
    checks++;
    if (o_eq_run !== 4'd0) begin errors++; $display("FAIL eq_run_break got %0d expected 0", o_eq_run); end
  endtask

  task automatic test_clr_accept();
    i_valid = 1; i_ready = 1; i_signed = 0; i_a = 8'hE0; i_b = 8'h01;
    tick();
    i_clr = 1; i_a = 8'h05; i_b = 8'h05;
    tick();
    i_clr = 0; i_valid = 0;
    checks++;
    if (o_max !== 8'h05 || o_min !== 8'h05 || o_eq_run !== 4'd1 || o_eq !== 1'b1) begin
      errors++; $display("FAIL clr_accept got max=%h min=%h run=%0d eq=%b expected 05 05 1 1",
                         o_max, o_min, o_eq_run, o_eq);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      i_valid  = ($urandom_range(0, 3) != 0);
      i_ready  = ($urandom_range(0, 2) != 0);
      i_clr    = ($urandom_range(0, 29) == 0);
      i_signed = 1'($urandom);
      i_a = DW'($urandom);
      i_b = ($urandom_range(0, 3) == 0) ? i_a : DW'($urandom);
      #1;
      checks++;
      if (o_ready !== (!m_valid || i_ready)) begin
        errors++; $display("FAIL rand_ready_%0d got %b expected %b", k, o_ready, !m_valid || i_ready);
      end
      tick();
      checks++;
      if ({o_valid, o_gt, o_lt, o_eq} !== {m_valid, m_gt, m_lt, m_eq}) begin
        errors++; $display("FAIL rand_result_%0d got %b expected %b", k,
                           {o_valid, o_gt, o_lt, o_eq}, {m_valid, m_gt, m_lt, m_eq});
      end
      checks++;
      if (o_max !== m_max || o_min !== m_min || int'(o_eq_run) !== m_run) begin
        errors++; $display("FAIL rand_track_%0d got max=%h min=%h run=%0d expected %h %h %0d",
                           k, o_max, o_min, o_eq_run, m_max, m_min, m_run);
      end
    end
    i_clr = 0;
  endtask

  task automatic test_async_reset();
    i_valid = 1; i_ready = 0; i_signed = 0; i_a = 8'h44; i_b = 8'h22;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({o_valid, o_gt, o_lt, o_eq} !== 4'b0000 || o_max !== 8'h00 || o_min !== 8'h00 || o_eq_run !== 4'd0) begin
      errors++; $display("FAIL async_reset got flags=%b max=%h min=%h run=%0d expected all 0",
                         {o_valid, o_gt, o_lt, o_eq}, o_max, o_min, o_eq_run);
    end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b expected 1", o_ready); end
    i_valid = 0; i_ready = 1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_after got v=%b rdy=%b expected 0 1", o_valid, o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_backpressure();
    test_eq_run();
    test_clr_accept();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
